rf_wport_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order writeback path and the long-latency unit (divider / late load return).
- Writeback normally has priority. The long-latency unit waits behind it, using a req/gnt handshake.
- A starvation guard freezes the pipeline for one cycle so that a waiting long-latency result is guaranteed to retire.
- Sits between the writeback stage outputs and the register file write port.

---
 rtl/rf_wport_arbiter.sv | 131 +++++++++++++
 tb/tb_rf_wport_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: writeback has priority, the long-latency unit waits on a
// req/gnt handshake, and a one-cycle pipeline freeze guarantees it eventually retires.
// Optional perf counters are built when RF_WPORT_ARB_PERF_EN is defined.
module rf_wport_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_waddr_i,
    input  logic [DATA_W-1:0] wb_wdata_i,
    input  logic              lu_req_i,
    input  logic [ADDR_W-1:0] lu_waddr_i,
    input  logic [DATA_W-1:0] lu_wdata_i,
    output logic              lu_gnt_o,
    output logic              stall_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o
`ifdef RF_WPORT_ARB_PERF_EN
    ,
    output logic [15:0]       force_cnt_o,
    output logic [15:0]       conflict_cnt_o
`endif
);

    typedef enum logic [0:0] {StNorm, StForce} state_e;

    localparam logic [CNT_W-1:0] MaxWait  = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] LastWait = CNT_W'(MAX_WAIT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              stall_q;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic wb_eff;
    logic same_addr;
    logic lu_blocked;

    assign wb_eff    = wb_we_i && (wb_waddr_i != '0) && (state_q == StNorm);
    assign same_addr = (lu_waddr_i == wb_waddr_i);
    // A same-address lu result is consumed but dropped: the younger wb write wins.
    assign lu_gnt_o   = !rst && lu_req_i && ((state_q == StForce) || !wb_eff || same_addr);
    assign lu_blocked = lu_req_i && !lu_gnt_o;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        if (wb_eff) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_waddr_i;
            rf_wdata_d = wb_wdata_i;
        end else if (lu_gnt_o && (lu_waddr_i != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = lu_waddr_i;
            rf_wdata_d = lu_wdata_i;
        end

        if (state_q == StForce) begin
            state_d    = StNorm;
            wait_cnt_d = '0;
        end else if (lu_blocked) begin
            if (wait_cnt_q == LastWait) begin
                state_d = StForce;
            end
            wait_cnt_d = (wait_cnt_q == MaxWait) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StNorm;
            wait_cnt_q <= '0;
            stall_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= (state_d == StForce);
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign stall_o    = stall_q;
    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

`ifdef RF_WPORT_ARB_PERF_EN
    logic [15:0] force_cnt_q, conflict_cnt_q;
    logic        force_entry;
    logic        conflict;

    assign force_entry = (state_q == StNorm) && (state_d == StForce);
    assign conflict    = wb_eff && lu_req_i && same_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            force_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (force_entry && (force_cnt_q != 16'hFFFF)) begin
                force_cnt_q <= force_cnt_q + 16'd1;
            end
            if (conflict && (conflict_cnt_q != 16'hFFFF)) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
        end
    end

    assign force_cnt_o    = force_cnt_q;
    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed self-checking bench for rf_wport_arbiter (default build, MAX_WAIT=4).
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        lu_req_i;
    logic [4:0]  lu_waddr_i;
    logic [31:0] lu_wdata_i;
    logic        lu_gnt_o;
    logic        stall_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    int n_cmp = 0;
    int n_err = 0;

    rf_wport_arbiter #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .MAX_WAIT(4),
        .CNT_W   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we_i   (wb_we_i),
        .wb_waddr_i(wb_waddr_i),
        .wb_wdata_i(wb_wdata_i),
        .lu_req_i  (lu_req_i),
        .lu_waddr_i(lu_waddr_i),
        .lu_wdata_i(lu_wdata_i),
        .lu_gnt_o  (lu_gnt_o),
        .stall_o   (stall_o),
        .rf_we_o   (rf_we_o),
        .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input string tag, input logic we, input logic [4:0] a,
                            input logic [31:0] d);
        check_eq({tag, ".we"}, 32'(rf_we_o), 32'(we));
        check_eq({tag, ".addr"}, 32'(rf_waddr_o), 32'(a));
        check_eq({tag, ".data"}, rf_wdata_o, d);
    endtask

    task automatic drive(input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                         input logic lreq, input logic [4:0] la, input logic [31:0] ld);
        wb_we_i    = wwe;
        wb_waddr_i = wa;
        wb_wdata_i = wd;
        lu_req_i   = lreq;
        lu_waddr_i = la;
        lu_wdata_i = ld;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1);
        #12;
        check_eq("rst.stall", 32'(stall_o), 32'd0);
        check_rf("rst", 1'b0, 5'd0, 32'd0);
        check_eq("rst.gnt", 32'(lu_gnt_o), 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // wb only
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        #1 check_eq("wb.gnt", 32'(lu_gnt_o), 32'd0);
        cyc();
        check_rf("wb", 1'b1, 5'd5, 32'hDEADBEEF);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cyc();
        check_rf("idle_hold", 1'b0, 5'd5, 32'hDEADBEEF);

        // lu only
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678);
        #1 check_eq("lu.gnt", 32'(lu_gnt_o), 32'd1);
        cyc();
        check_rf("lu", 1'b1, 5'd7, 32'h12345678);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cyc();

        // Starvation: wb to x3 every cycle, lu to x9 held
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 32'd100 + 32'(i), 1'b1, 5'd9, 32'h99);
            #1 check_eq($sformatf("starve%0d.gnt", i), 32'(lu_gnt_o), 32'd0);
            check_eq($sformatf("starve%0d.stall_pre", i), 32'(stall_o), 32'd0);
            cyc();
            check_rf($sformatf("starve%0d", i), 1'b1, 5'd3, 32'd100 + 32'(i));
        end
        // FORCE cycle: pipeline frozen, next wb (104) presented but ignored
        drive(1'b1, 5'd3, 32'd104, 1'b1, 5'd9, 32'h99);
        #1 check_eq("force.stall", 32'(stall_o), 32'd1);
        check_eq("force.gnt", 32'(lu_gnt_o), 32'd1);
        cyc();
        check_rf("force", 1'b1, 5'd9, 32'h99);
        check_eq("post_force.stall", 32'(stall_o), 32'd0);
        drive(1'b1, 5'd3, 32'd104, 1'b0, 5'd0, 32'd0);
        cyc();
        check_rf("resume", 1'b1, 5'd3, 32'd104);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cyc();
        check_eq("resume_idle.we", 32'(rf_we_o), 32'd0);

        // Same-address conflict: wb wins, single write
        drive(1'b1, 5'd4, 32'hA, 1'b1, 5'd4, 32'hB);
        #1 check_eq("same.gnt", 32'(lu_gnt_o), 32'd1);
        cyc();
        check_rf("same", 1'b1, 5'd4, 32'hA);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cyc();
        check_eq("same_single.we", 32'(rf_we_o), 32'd0);

        // x0 from both sources
        drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
        #1 check_eq("x0.gnt", 32'(lu_gnt_o), 32'd1);
        cyc();
        check_rf("x0", 1'b0, 5'd4, 32'hA);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cyc();

        // Reset asserted during FORCE
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 32'd200 + 32'(i), 1'b1, 5'd9, 32'h77);
            cyc();
        end
        check_eq("rf_force.stall", 32'(stall_o), 32'd1);
        check_eq("rf_force.we", 32'(rf_we_o), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rstf.stall", 32'(stall_o), 32'd0);
        check_eq("rstf.we", 32'(rf_we_o), 32'd0);
        check_eq("rstf.gnt", 32'(lu_gnt_o), 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h77);
        @(negedge clk);
        rst = 1'b0;
        #1 check_eq("after_rst.gnt", 32'(lu_gnt_o), 32'd1);
        check_eq("after_rst.stall", 32'(stall_o), 32'd0);
        cyc();
        check_rf("after_rst", 1'b1, 5'd9, 32'h77);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
